// File: rtl/mnist_pkg.sv
// -----------------------------------------------------------------------------
// mnist_pkg
//   Shared constants and types for the MNIST inference pipeline.
//   Layer-1 feature-map geometry, the feature-map word width and the
//   state encoding of the layer-1 interleaver FSM.
// -----------------------------------------------------------------------------
package mnist_pkg;

  localparam int L1_NUM_CH = 6;    // conv1 output channels
  localparam int L1_PIX    = 144;  // 12x12 pixels per pooled map
  localparam int FMAP_DW   = 32;   // feature-map word width

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } l1_state_e;

endpackage : mnist_pkg

// File: rtl/fmap_bank.sv
// -----------------------------------------------------------------------------
// fmap_bank
//   Simple dual-port RAM holding one feature-map channel.
//   One write port, one registered read port, both on clk.
//   The read register only loads when re_i is high, so rdata_o holds its
//   last value between reads. Only the read register is reset; the array
//   itself is never cleared.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (read register only)
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   re_i     in   read enable
//   raddr_i  in   read address
//   rdata_o  out  registered read data (1-cycle latency)
// -----------------------------------------------------------------------------
module fmap_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 144,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage array: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : fmap_bank

// File: rtl/layer1_fmap_interleaver.sv
// -----------------------------------------------------------------------------
// layer1_fmap_interleaver
//   Captures one channel-major layer-1 frame (6 x 144 words) into six
//   channel banks, then replays it pixel-major as 144 six-channel beats.
//   Fill and drain never overlap.
// Ports:
//   clk              in   clock
//   rst_n            in   asynchronous active-low reset
//   valid_in         in   upstream word valid
//   data_in          in   upstream word (channel-major order)
//   in_ready         out  word accepted when valid_in & in_ready (FILL only)
//   out_ch0..out_ch5 out  pixel p of channels 0..5
//   out_valid        out  out_ch* carry a valid beat (no backpressure)
//   out_last         out  beat for the final pixel
//   busy             out  high while draining
// -----------------------------------------------------------------------------
module layer1_fmap_interleaver
  import mnist_pkg::*;
#(
  parameter int DATA_WIDTH = FMAP_DW,
  parameter int NUM_CH     = L1_NUM_CH,
  parameter int PIX        = L1_PIX,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_ch0,
  output logic [DATA_WIDTH-1:0] out_ch1,
  output logic [DATA_WIDTH-1:0] out_ch2,
  output logic [DATA_WIDTH-1:0] out_ch3,
  output logic [DATA_WIDTH-1:0] out_ch4,
  output logic [DATA_WIDTH-1:0] out_ch5,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] PIX_LAST = ADDR_WIDTH'(PIX - 1);
  localparam logic [2:0]            CH_LAST  = 3'(NUM_CH - 1);

  l1_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_pix_q, wr_pix_d;
  logic [2:0]            wr_ch_q, wr_ch_d;
  logic [ADDR_WIDTH-1:0] rd_pix_q, rd_pix_d;
  logic                  out_valid_q, out_last_q;

  logic                  accept;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data [NUM_CH];

  // ---------------------------------------------------------------------------
  // Next-state / control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    wr_pix_d = wr_pix_q;
    wr_ch_d  = wr_ch_q;
    rd_pix_d = rd_pix_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    rd_en    = 1'b0;

    unique case (state_q)
      FILL: begin
        in_ready = 1'b1;
        accept   = valid_in;
        if (accept) begin
          if (wr_pix_q == PIX_LAST) begin
            wr_pix_d = '0;
            if (wr_ch_q == CH_LAST) begin
              // Final word of the frame: counters are left clean for the next fill.
              wr_ch_d = '0;
              state_d = DRAIN;
            end else begin
              wr_ch_d = wr_ch_q + 3'd1;
            end
          end else begin
            wr_pix_d = wr_pix_q + 1'b1;
          end
        end
      end

      DRAIN: begin
        // One pixel address per cycle to all banks at once.
        rd_en = 1'b1;
        if (rd_pix_q == PIX_LAST) begin
          rd_pix_d = '0;
          state_d  = FILL;
        end else begin
          rd_pix_d = rd_pix_q + 1'b1;
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counters and output strobes
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      wr_pix_q    <= '0;
      wr_ch_q     <= '0;
      rd_pix_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_pix_q    <= wr_pix_d;
      wr_ch_q     <= wr_ch_d;
      rd_pix_q    <= rd_pix_d;
      // Strobes delayed by one cycle to line up with the registered bank read.
      out_valid_q <= rd_en;
      out_last_q  <= rd_en && (rd_pix_q == PIX_LAST);
    end
  end

  // ---------------------------------------------------------------------------
  // Channel banks; write enable decoded from the channel counter
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_bank
      fmap_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (PIX),
        .ADDR_WIDTH (ADDR_WIDTH)
      ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (accept && (wr_ch_q == 3'(gi))),
        .waddr_i (wr_pix_q),
        .wdata_i (data_in),
        .re_i    (rd_en),
        .raddr_i (rd_pix_q),
        .rdata_o (rd_data[gi])
      );
    end
  endgenerate

  assign out_ch0   = rd_data[0];
  assign out_ch1   = rd_data[1];
  assign out_ch2   = rd_data[2];
  assign out_ch3   = rd_data[3];
  assign out_ch4   = rd_data[4];
  assign out_ch5   = rd_data[5];
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == DRAIN);

endmodule : layer1_fmap_interleaver

// File: tb/tb_layer1_fmap_interleaver.sv
// -----------------------------------------------------------------------------
// tb_layer1_fmap_interleaver
//   Frames are generated as a flat list of 864 words in arrival order; the
//   expected beat p, channel c is simply word c*144+p of that list.
// -----------------------------------------------------------------------------
module tb_layer1_fmap_interleaver;

  localparam int NCH   = 6;
  localparam int NPIX  = 144;
  localparam int NWORD = NCH * NPIX;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] data_in;
  logic        in_ready;
  logic [31:0] out_ch0, out_ch1, out_ch2, out_ch3, out_ch4, out_ch5;
  logic        out_valid;
  logic        out_last;
  logic        busy;

  layer1_fmap_interleaver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .in_ready  (in_ready),
    .out_ch0   (out_ch0),
    .out_ch1   (out_ch1),
    .out_ch2   (out_ch2),
    .out_ch3   (out_ch3),
    .out_ch4   (out_ch4),
    .out_ch5   (out_ch5),
    .out_valid (out_valid),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] outs [NCH];
  assign outs[0] = out_ch0;
  assign outs[1] = out_ch1;
  assign outs[2] = out_ch2;
  assign outs[3] = out_ch3;
  assign outs[4] = out_ch4;
  assign outs[5] = out_ch5;

  int checks = 0;
  int errors = 0;

  logic [31:0] cur_w [NWORD];
  logic [31:0] nxt_w [NWORD];
  logic [31:0] hold_exp [NCH];

  typedef struct {
    int mode;       // 0: ch*1000+pix pattern, 1: random words
    int gap_pct;    // percentage of idle cycles between words
    bit hold_next;  // keep valid_in high through drain with next frame's word 0
    int next_mode;  // data mode of the following frame when hold_next
    int exp_beats;  // expected out_valid beats
    int exp_lat;    // expected cycles from last accept to first beat
  } frame_vec_t;

  frame_vec_t tbl [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic gen_next(input int mode);
    for (int k = 0; k < NWORD; k++) begin
      nxt_w[k] = (mode == 0) ? 32'((k / NPIX) * 1000 + (k % NPIX)) : $urandom;
    end
  endtask

  // Presents one word; inputs are driven 1 time unit after a rising edge.
  task automatic send_word(input logic [31:0] w, input int gap_pct);
    int idle;
    idle = 0;
    while (idle < 5 && $urandom_range(99) < gap_pct) begin
      valid_in = 1'b0;
      @(posedge clk); #1;
      idle++;
    end
    valid_in = 1'b1;
    data_in  = w;
    chk("fill_in_ready", in_ready, 1);
    chk("fill_out_valid", out_valid, 0);
    chk("fill_busy", busy, 0);
    chk("fill_out_last", out_last, 0);
    for (int c = 0; c < NCH; c++) chk($sformatf("hold_out_ch%0d", c), outs[c], hold_exp[c]);
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic run_frame(input int gap_pct, input bit skip_first, input bit hold_next,
                           input int next_mode, output int beats, output int first_lat);
    for (int k = 0; k < NWORD; k++) cur_w[k] = nxt_w[k];
    for (int k = (skip_first ? 1 : 0); k < NWORD; k++) send_word(cur_w[k], gap_pct);
    // Now in cycle T+1 relative to the final accept edge T.
    if (hold_next) begin
      gen_next(next_mode);
      valid_in = 1'b1;
      data_in  = nxt_w[0];
    end
    beats     = 0;
    first_lat = -1;
    for (int n = 1; n <= NPIX + 1; n++) begin
      if (out_valid) begin
        beats++;
        if (first_lat < 0) first_lat = n;
      end
      chk($sformatf("drain_busy_n%0d", n), busy, (n <= NPIX) ? 1 : 0);
      chk($sformatf("drain_in_ready_n%0d", n), in_ready, (n == NPIX + 1) ? 1 : 0);
      chk($sformatf("drain_out_valid_n%0d", n), out_valid, (n >= 2) ? 1 : 0);
      chk($sformatf("drain_out_last_n%0d", n), out_last, (n == NPIX + 1) ? 1 : 0);
      if (n >= 2) begin
        for (int c = 0; c < NCH; c++)
          chk($sformatf("beat%0d_ch%0d", n - 2, c), outs[c], cur_w[c * NPIX + n - 2]);
      end
      if (n <= NPIX) begin
        @(posedge clk); #1;
      end
    end
    for (int c = 0; c < NCH; c++) hold_exp[c] = cur_w[c * NPIX + NPIX - 1];
    // With hold_next the held word is accepted on this edge.
    @(posedge clk); #1;
    valid_in = 1'b0;
    chk("post_drain_out_valid", out_valid, 0);
  endtask

  initial begin
    int beats, lat;
    bit preloaded;

    tbl[0] = '{mode: 0, gap_pct: 0,  hold_next: 0, next_mode: 0, exp_beats: 144, exp_lat: 2};
    tbl[1] = '{mode: 0, gap_pct: 30, hold_next: 0, next_mode: 0, exp_beats: 144, exp_lat: 2};
    tbl[2] = '{mode: 0, gap_pct: 0,  hold_next: 1, next_mode: 1, exp_beats: 144, exp_lat: 2};
    tbl[3] = '{mode: 1, gap_pct: 0,  hold_next: 0, next_mode: 0, exp_beats: 144, exp_lat: 2};
    tbl[4] = '{mode: 1, gap_pct: 20, hold_next: 0, next_mode: 0, exp_beats: 144, exp_lat: 2};

    for (int c = 0; c < NCH; c++) hold_exp[c] = '0;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 20; i++) begin
      chk("idle_in_ready", in_ready, 1);
      chk("idle_out_valid", out_valid, 0);
      for (int c = 0; c < NCH; c++) chk($sformatf("idle_out_ch%0d", c), outs[c], 0);
      @(posedge clk); #1;
    end

    // Table-driven frames.
    preloaded = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (!preloaded) gen_next(tbl[i].mode);
      run_frame(tbl[i].gap_pct, preloaded, tbl[i].hold_next, tbl[i].next_mode, beats, lat);
      chk($sformatf("frame%0d_beats", i), beats, tbl[i].exp_beats);
      chk($sformatf("frame%0d_latency", i), lat, tbl[i].exp_lat);
      $display("frame %0d: gap %0d%% hold %0d beats %0d latency %0d", i, tbl[i].gap_pct,
               tbl[i].hold_next, beats, lat);
      preloaded = tbl[i].hold_next;
    end

    // Reset while ch3 pix50 is being offered.
    gen_next(1);
    for (int k = 0; k < NWORD; k++) cur_w[k] = nxt_w[k];
    for (int k = 0; k < 3 * NPIX + 50; k++) send_word(cur_w[k], 0);
    valid_in = 1'b1;
    data_in  = cur_w[3 * NPIX + 50];
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_last", out_last, 0);
    chk("midrst_busy", busy, 0);
    for (int c = 0; c < NCH; c++) chk($sformatf("midrst_out_ch%0d", c), outs[c], 0);
    valid_in = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < NCH; c++) hold_exp[c] = '0;
    $display("reset asserted mid-frame at ch3 pix50");

    gen_next(1);
    run_frame(10, 1'b0, 1'b0, 0, beats, lat);
    chk("postrst_beats", beats, 144);
    chk("postrst_latency", lat, 2);
    $display("post-reset frame: beats %0d latency %0d", beats, lat);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_layer1_fmap_interleaver
